// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer
//
// Colour sequencer placed between the manual duty registers and the three
// PWM comparators. It owns the duty values the comparators receive.
//   - Manual mode (IDLE): the duties follow MAN_* with one cycle of latency.
//   - Auto mode (RAMP/HOLD): the duties step through a fixed table of four
//     colour keyframes. Each channel moves one LSB per CE_IN tick. Each
//     keyframe is held for HOLD_TICKS ticks, and the table wraps after key 3.
//
// Ports
//   CLK, CLR                         clock, asynchronous active-low reset
//   CE_IN                            prescaler tick, one CLK wide
//   EN                               1 = auto mode, 0 = manual mode
//   STEP                             one-cycle pulse, skips to the next keyframe
//   MAN_RED/GREEN/BLUE [DUTY_W]      manual duties
//   RED/GREEN/BLUE_DUTY [DUTY_W]     registered duties to the comparators
//   KEY_IDX [2]                      current target keyframe
//   BUSY                             1 while ramping
//   AUTO                             1 while ramping or holding
//   DBG_STATE [2]                    raw FSM state: 0 IDLE, 1 RAMP, 2 HOLD
//
// Handshake note: there is no valid/ready traffic in this block. CE_IN,
// STEP and EN are level/pulse inputs, and they are sampled only on the
// rising edge of CLK. When inputs conflict, priority is EN=0 first, then
// STEP, then CE_IN.

module rgb_fade_sequencer #(
  parameter int DUTY_W     = 4,
  parameter int HOLD_TICKS = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE_IN,
  input  logic              EN,
  input  logic              STEP,
  input  logic [DUTY_W-1:0] MAN_RED,
  input  logic [DUTY_W-1:0] MAN_GREEN,
  input  logic [DUTY_W-1:0] MAN_BLUE,
  output logic [DUTY_W-1:0] RED_DUTY,
  output logic [DUTY_W-1:0] GREEN_DUTY,
  output logic [DUTY_W-1:0] BLUE_DUTY,
  output logic [1:0]        KEY_IDX,
  output logic              BUSY,
  output logic              AUTO,
  output logic [1:0]        DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [DUTY_W-1:0] FULL      = '1;
  localparam logic [DUTY_W-1:0] ONE       = DUTY_W'(1);
  // Hold finishes on the tick that would bring the count to HOLD_TICKS.
  localparam logic [7:0]        HOLD_LAST = 8'(HOLD_TICKS - 1);

  state_t            state_q, state_d;
  logic [1:0]        key_q, key_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DUTY_W-1:0] red_q, red_d;
  logic [DUTY_W-1:0] green_q, green_d;
  logic [DUTY_W-1:0] blue_q, blue_d;

  logic [DUTY_W-1:0] tgt_red, tgt_green, tgt_blue;
  logic              at_target;

  // Move one LSB toward the target. Comparing first means the value can
  // never overshoot the target or wrap around.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt
  );
    if (cur < tgt)      return cur + ONE;
    else if (cur > tgt) return cur - ONE;
    else                return cur;
  endfunction

  // Keyframe table: key 0 red, key 1 green, key 2 blue, key 3 white.
  always_comb begin
    tgt_red   = (key_q == 2'd0 || key_q == 2'd3) ? FULL : '0;
    tgt_green = (key_q == 2'd1 || key_q == 2'd3) ? FULL : '0;
    tgt_blue  = (key_q == 2'd2 || key_q == 2'd3) ? FULL : '0;
  end

  assign at_target = (red_q == tgt_red) && (green_q == tgt_green) &&
                     (blue_q == tgt_blue);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;

    case (state_q)
      IDLE: begin
        red_d   = MAN_RED;
        green_d = MAN_GREEN;
        blue_d  = MAN_BLUE;
        key_d   = 2'd0;
        cnt_d   = 8'd0;
        if (EN) state_d = RAMP;
      end

      RAMP: begin
        if (!EN) begin
          state_d = IDLE;
          red_d   = MAN_RED;
          green_d = MAN_GREEN;
          blue_d  = MAN_BLUE;
          key_d   = 2'd0;
          cnt_d   = 8'd0;
        end else if (STEP) begin
          // Skip to the next keyframe; the duties stay frozen this cycle.
          key_d = key_q + 2'd1;
          cnt_d = 8'd0;
        end else if (at_target) begin
          // Covers both arrival after an update and entry already on target.
          state_d = HOLD;
          cnt_d   = 8'd0;
        end else if (CE_IN) begin
          red_d   = step_toward(red_q, tgt_red);
          green_d = step_toward(green_q, tgt_green);
          blue_d  = step_toward(blue_q, tgt_blue);
        end
      end

      HOLD: begin
        if (!EN) begin
          state_d = IDLE;
          red_d   = MAN_RED;
          green_d = MAN_GREEN;
          blue_d  = MAN_BLUE;
          key_d   = 2'd0;
          cnt_d   = 8'd0;
        end else if (STEP) begin
          state_d = RAMP;
          key_d   = key_q + 2'd1;
          cnt_d   = 8'd0;
        end else if (CE_IN) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = RAMP;
            key_d   = key_q + 2'd1;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      key_q   <= 2'd0;
      cnt_q   <= 8'd0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  // These are decoded straight from registers, so they change on the same
  // edge as the state register.
  assign RED_DUTY   = red_q;
  assign GREEN_DUTY = green_q;
  assign BLUE_DUTY  = blue_q;
  assign KEY_IDX    = key_q;
  assign BUSY       = (state_q == RAMP);
  assign AUTO       = (state_q == RAMP) || (state_q == HOLD);
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer.
// It uses directed stimulus. A behavioural colour model is checked every
// cycle, and literal checkpoints pin the model to hand-computed values.

module tb_rgb_fade_sequencer;

  localparam int DUTY_W     = 4;
  localparam int HOLD_TICKS = 8;
  localparam int FULL       = (1 << DUTY_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic              CLK = 1'b0;
  logic              CLR = 1'b1;
  logic              CE_IN = 1'b0;
  logic              EN = 1'b0;
  logic              STEP = 1'b0;
  logic [DUTY_W-1:0] MAN_RED = '0;
  logic [DUTY_W-1:0] MAN_GREEN = '0;
  logic [DUTY_W-1:0] MAN_BLUE = '0;
  logic [DUTY_W-1:0] RED_DUTY, GREEN_DUTY, BLUE_DUTY;
  logic [1:0]        KEY_IDX;
  logic              BUSY, AUTO;
  logic [1:0]        DBG_STATE;

  always #5 CLK = ~CLK;

  rgb_fade_sequencer #(.DUTY_W(DUTY_W), .HOLD_TICKS(HOLD_TICKS)) dut (
    .CLK(CLK), .CLR(CLR), .CE_IN(CE_IN), .EN(EN), .STEP(STEP),
    .MAN_RED(MAN_RED), .MAN_GREEN(MAN_GREEN), .MAN_BLUE(MAN_BLUE),
    .RED_DUTY(RED_DUTY), .GREEN_DUTY(GREEN_DUTY), .BLUE_DUTY(BLUE_DUTY),
    .KEY_IDX(KEY_IDX), .BUSY(BUSY), .AUTO(AUTO), .DBG_STATE(DBG_STATE)
  );

  int vectors = 0;
  int errors  = 0;
  bit chk_on  = 1'b0;

  // ---------------- behavioural model ----------------
  // m_auto: colour sequencing active. m_hold: parked on a keyframe.
  int m_duty[3] = '{0, 0, 0};
  int m_key     = 0;
  int m_cnt     = 0;
  bit m_auto    = 1'b0;
  bit m_hold    = 1'b0;

  // Channel ch is lit in keyframe k if k names that colour or k is white.
  function automatic int key_val(input int k, input int ch);
    return (k == 3 || k == ch) ? FULL : 0;
  endfunction

  function automatic bit on_key();
    bit ok = 1'b1;
    for (int ch = 0; ch < 3; ch++)
      if (m_duty[ch] != key_val(m_key, ch)) ok = 1'b0;
    return ok;
  endfunction

  always @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      m_duty = '{0, 0, 0};
      m_key = 0; m_cnt = 0; m_auto = 1'b0; m_hold = 1'b0;
    end else if (!m_auto || !EN) begin
      m_duty = '{int'(MAN_RED), int'(MAN_GREEN), int'(MAN_BLUE)};
      m_key = 0; m_cnt = 0; m_hold = 1'b0;
      m_auto = EN && !m_auto;
    end else if (STEP) begin
      m_key = (m_key + 1) % 4; m_cnt = 0; m_hold = 1'b0;
    end else if (!m_hold) begin
      if (on_key()) begin
        m_hold = 1'b1; m_cnt = 0;
      end else if (CE_IN) begin
        for (int ch = 0; ch < 3; ch++) begin
          if (m_duty[ch] < key_val(m_key, ch)) m_duty[ch]++;
          else if (m_duty[ch] > key_val(m_key, ch)) m_duty[ch]--;
        end
      end
    end else if (CE_IN) begin
      m_cnt++;
      if (m_cnt == HOLD_TICKS) begin
        m_key = (m_key + 1) % 4; m_cnt = 0; m_hold = 1'b0;
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge CLK) begin
    if (chk_on && CLR) begin
      vectors++;
      if (RED_DUTY !== DUTY_W'(m_duty[0]) || GREEN_DUTY !== DUTY_W'(m_duty[1]) ||
          BLUE_DUTY !== DUTY_W'(m_duty[2]) || KEY_IDX !== 2'(m_key) ||
          BUSY !== (m_auto && !m_hold) || AUTO !== m_auto) begin
        errors++;
        $display("FAIL model t=%0t got rgb=%0d/%0d/%0d key=%0d busy=%0b auto=%0b need rgb=%0d/%0d/%0d key=%0d busy=%0b auto=%0b",
                 $time, RED_DUTY, GREEN_DUTY, BLUE_DUTY, KEY_IDX, BUSY, AUTO,
                 m_duty[0], m_duty[1], m_duty[2], m_key, m_auto && !m_hold, m_auto);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d need %0d", name, act, exp_v);
    end
  endtask

  task automatic check_rgb(input string name, input int r, input int g, input int b);
    check({name, ".r"}, 32'(RED_DUTY), r);
    check({name, ".g"}, 32'(GREEN_DUTY), g);
    check({name, ".b"}, 32'(BLUE_DUTY), b);
  endtask

  // ---------------- driver tasks ----------------
  // Apply the inputs for one rising edge, then return at the next falling edge.
  task automatic cyc(input logic ce, input logic st);
    CE_IN = ce;
    STEP  = st;
    @(negedge CLK);
  endtask

  // n CE_IN pulses, each followed by one idle cycle.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
  endtask

  task automatic set_man(input int r, input int g, input int b);
    MAN_RED = DUTY_W'(r); MAN_GREEN = DUTY_W'(g); MAN_BLUE = DUTY_W'(b);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset and passthrough
    #1 CLR = 1'b0;
    #2;
    check_rgb("reset", 0, 0, 0);
    check("reset.key", 32'(KEY_IDX), 0);
    check("reset.auto", 32'(AUTO), 0);
    check("reset.busy", 32'(BUSY), 0);
    set_man(3, 7, 11);
    @(negedge CLK);
    check_rgb("reset_held", 0, 0, 0);
    CLR = 1'b1;
    chk_on = 1'b1;
    cyc(1'b0, 1'b0);
    check_rgb("passthru", 3, 7, 11);
    check("passthru.auto", 32'(AUTO), 0);

    // Ramp to key 0
    EN = 1'b1;
    cyc(1'b0, 1'b0);
    check("ramp.busy", 32'(BUSY), 1);
    ticks(11);
    cyc(1'b1, 1'b0);
    check_rgb("ramp12", 15, 0, 0);
    check("ramp12.busy", 32'(BUSY), 1);
    cyc(1'b0, 1'b0);
    check("hold0.busy", 32'(BUSY), 0);
    check("hold0.auto", 32'(AUTO), 1);

    // Hold and advance
    ticks(7);
    check("hold7.key", 32'(KEY_IDX), 0);
    check_rgb("hold7", 15, 0, 0);
    cyc(1'b1, 1'b0);
    check("hold8.key", 32'(KEY_IDX), 1);
    check("hold8.busy", 32'(BUSY), 1);
    cyc(1'b0, 1'b0);
    ticks(15);
    check_rgb("key1", 0, 15, 0);

    // Wrap-around
    ticks(8);
    ticks(15);
    check_rgb("key2", 0, 0, 15);
    ticks(8);
    check("key3.idx", 32'(KEY_IDX), 3);
    ticks(15);
    check_rgb("key3", 15, 15, 15);
    ticks(8);
    check("wrap.key", 32'(KEY_IDX), 0);
    check("wrap.busy", 32'(BUSY), 1);
    ticks(14);
    check_rgb("wrap14", 15, 1, 1);
    check("wrap14.busy", 32'(BUSY), 1);
    ticks(1);
    check_rgb("wrap15", 15, 0, 0);
    check("wrap15.busy", 32'(BUSY), 0);

    // STEP together with CE_IN in RAMP
    ticks(8);
    ticks(3);
    check_rgb("ramp3", 12, 3, 0);
    cyc(1'b1, 1'b1);
    check_rgb("step_ramp", 12, 3, 0);
    check("step_ramp.key", 32'(KEY_IDX), 2);
    ticks(2);
    check_rgb("after_step", 10, 1, 2);

    // STEP in HOLD at count 5
    ticks(13);
    check("hold2.busy", 32'(BUSY), 0);
    ticks(5);
    cyc(1'b0, 1'b1);
    check("step_hold.key", 32'(KEY_IDX), 3);
    check("step_hold.busy", 32'(BUSY), 1);
    ticks(4);
    check_rgb("ramp_k3", 4, 4, 15);

    // Abort: EN=0 wins over STEP and CE_IN
    set_man(5, 9, 2);
    EN = 1'b0;
    cyc(1'b1, 1'b1);
    check_rgb("abort", 5, 9, 2);
    check("abort.auto", 32'(AUTO), 0);
    check("abort.key", 32'(KEY_IDX), 0);
    cyc(1'b0, 1'b1);
    check("idle_step.auto", 32'(AUTO), 0);
    check_rgb("idle_step", 5, 9, 2);
    set_man(1, 2, 3);
    cyc(1'b0, 1'b0);
    check_rgb("idle_man", 1, 2, 3);

    // Asynchronous reset mid-HOLD
    EN = 1'b1;
    cyc(1'b0, 1'b0);
    ticks(14);
    check_rgb("key0_again", 15, 0, 0);
    check("key0_again.busy", 32'(BUSY), 0);
    ticks(3);
    #2 CLR = 1'b0;
    #1;
    check_rgb("async_rst", 0, 0, 0);
    check("async_rst.auto", 32'(AUTO), 0);
    check("async_rst.busy", 32'(BUSY), 0);
    check("async_rst.key", 32'(KEY_IDX), 0);
    @(negedge CLK);
    CLR = 1'b1;
    cyc(1'b0, 1'b0);
    check_rgb("resume", 1, 2, 3);
    check("resume.busy", 32'(BUSY), 1);
    ticks(3);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rgb_fade_sequencer.md
# rgb_fade_sequencer

Automatic colour-sequencing controller for the RGB PWM LED driver. It sits between the manual colour-duty registers and the three colour comparators, and it owns the duty values those comparators receive. In manual mode it forwards the manual duties unchanged. In auto mode it ramps all three channels, one step per prescaler tick, through a fixed table of four colour keyframes, holds each keyframe for a programmable number of ticks, and wraps around the table.

## Interface
- DUTY_W, 4: width of each colour duty value.
- HOLD_TICKS, 8: number of CE_IN ticks to hold each keyframe once reached. Legal range is 1..255.

- CLK  in  1  system clock.
- CLR  in  1  asynchronous, active-low reset.
- CE_IN  in  1  prescaler tick, one CLK cycle wide.
- EN  in  1  level input; 1 selects auto mode, 0 selects manual mode.
- STEP  in  1  one-cycle pulse (already debounced); skips to the next keyframe.
- MAN_RED, MAN_GREEN, MAN_BLUE  in  DUTY_W each  manual duties, used in manual mode.
- RED_DUTY, GREEN_DUTY, BLUE_DUTY  out  DUTY_W each  registered duties to the comparators.
- KEY_IDX  out  2  current target keyframe index.
- BUSY  out  1  1 while in RAMP.
- AUTO  out  1  1 in RAMP or HOLD.

## Operation
- Keyframe table (R, G, B), with FULL = 2^DUTY_W − 1:
  - key 0: (FULL, 0, 0)
  - key 1: (0, FULL, 0)
  - key 2: (0, 0, FULL)
  - key 3: (FULL, FULL, FULL)
- States are IDLE, RAMP and HOLD. The reset state is IDLE.
- IDLE:
  - Every CLK cycle, each duty output loads its MAN_* input.
  - KEY_IDX is held at 0.
  - EN=1 → RAMP. The ramp starts from the current output values and targets key 0.
- RAMP:
  - On each CE_IN, every channel moves one step toward its target: +1 if below, −1 if above, unchanged if equal.
  - A channel never overshoots or wraps.
  - When all three channels equal the target (after an update, or already on entry), the next cycle enters HOLD and the hold counter clears to 0.
- HOLD:
  - Duties are frozen.
  - Each CE_IN increments the hold counter.
  - On the CE_IN that brings the count to HOLD_TICKS: KEY_IDX increments (3 wraps to 0), the counter clears, and the state goes to RAMP.
- STEP in RAMP or HOLD:
  - KEY_IDX increments with wrap, the hold counter clears, and the state goes to RAMP.
  - Duties do not move in that cycle, even if CE_IN is also high.
- STEP in IDLE is ignored.
- EN=0 in RAMP or HOLD:
  - The next cycle is IDLE; duties load MAN_* in that same edge.
  - EN takes priority over STEP and CE_IN.
- The hold counter is 8 bits wide. The ramp arithmetic is DUTY_W bits wide with no carry out.
- CE_IN, STEP and EN are sampled only on the rising edge of CLK.

## Timing
- All outputs are registered. On reset: every duty = 0, KEY_IDX = 0, BUSY = 0, AUTO = 0.
- Manual passthrough latency is 1 CLK: MAN_* at edge n appears on the outputs after edge n.
- Ramp rate is at most 1 LSB per CE_IN. Worst-case ramp length is FULL CE_IN ticks (15 for DUTY_W=4).
- A keyframe is held for exactly HOLD_TICKS CE_IN pulses, counted after the cycle in which HOLD is entered.
- BUSY and AUTO change on the same edge as the state register.
- Reset asserted in any state takes effect immediately, with no CLK edge needed. After release, the block resumes from IDLE on the first CLK edge.

## Test plan
- **Reset and passthrough.** Hold CLR low, then release. Drive EN=0 and MAN = (3, 7, 11).
  - During reset: all outputs 0.
  - One CLK after MAN is applied: outputs = (3, 7, 11), AUTO = 0.
- **Ramp to key 0.** From outputs (3, 7, 11), raise EN and apply 15 CE_IN pulses.
  - Every CE_IN: R +1, G −1, B −1, saturating at the target.
  - Outputs reach (15, 0, 0) after 12 ticks. BUSY drops and the state is HOLD one cycle later.
- **Hold and advance.** With HOLD_TICKS=8, in HOLD at key 0:
  - After 7 CE_IN: KEY_IDX = 0, duties unchanged.
  - After the 8th CE_IN: KEY_IDX = 1 and BUSY = 1.
  - After 15 further CE_IN: duties = (0, 15, 0).
- **Wrap-around.** Run the sequence through key 3.
  - Duties reach (15, 15, 15).
  - After the hold, KEY_IDX = 0 and the ramp back to (15, 0, 0) takes 15 ticks.
- **STEP collisions.**
  - STEP together with CE_IN in RAMP: duties unchanged that cycle, KEY_IDX increments.
  - STEP in IDLE: no change.
  - STEP in HOLD at count 5: counter clears, state goes to RAMP.
- **Abort.**
  - Drop EN mid-ramp: the next cycle has outputs = MAN_*, AUTO = 0, KEY_IDX = 0.
  - Pulse CLR low mid-HOLD: all outputs go to 0 asynchronously, before the next CLK edge.
